// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte producers.
// Define UART_ARB_ID_HDR_EN to precede every data byte with a header byte ID_BASE + grant index.
module uart_tx_arbiter #(
    parameter int         N_REQ        = 4,
    parameter logic [7:0] ID_BASE      = 8'hA0,
    parameter int         DONE_TIMEOUT = 2048
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req_dv,
    input  logic [8*N_REQ-1:0] i_req_byte,
    output logic [N_REQ-1:0]   o_req_ack,
    output logic               o_tx_dv,
    output logic [7:0]         o_tx_byte,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic [2:0]         o_grant_id,
    output logic               o_timeout
);
    localparam int              CW      = $clog2(DONE_TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_LAST = CW'(DONE_TIMEOUT);

`ifdef UART_ARB_ID_HDR_EN
    typedef enum logic [2:0] {IDLE, HDR_ISSUE, HDR_WAIT, ISSUE, WAIT_DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE} state_t;
`endif

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [7:0] data;
    } grant_t;

    state_t                  state, state_nxt;
    logic [N_REQ-1:0][7:0]   req_bytes;
    grant_t                  rr;
    logic [2:0]              last, last_nxt;
    logic [CW-1:0]           cnt, cnt_nxt, cnt_inc;
    logic                    wd_hit;
    logic                    tx_dv_nxt, timeout_nxt;
    logic [N_REQ-1:0]        ack_nxt;
    logic [7:0]              byte_nxt;
    logic [2:0]              grant_nxt;
`ifdef UART_ARB_ID_HDR_EN
    logic [7:0]              data_q, data_nxt;
`endif

    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        assign req_bytes[k] = i_req_byte[8*k +: 8];
    end

    // Lanes above the pointer override lanes at or below it, so the search starts at last+1 and wraps.
    always_comb begin
        rr = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req_dv[k] && k <= int'(last)) begin
                rr.hit  = 1'b1;
                rr.idx  = 3'(k);
                rr.data = req_bytes[k];
            end
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req_dv[k] && k > int'(last)) begin
                rr.hit  = 1'b1;
                rr.idx  = 3'(k);
                rr.data = req_bytes[k];
            end
        end
    end

    assign cnt_inc = cnt + CW'(1);
    assign wd_hit  = (cnt_inc == TO_LAST);

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        grant_nxt   = o_grant_id;
        byte_nxt    = o_tx_byte;
        cnt_nxt     = cnt;
        tx_dv_nxt   = 1'b0;
        ack_nxt     = '0;
        timeout_nxt = 1'b0;
`ifdef UART_ARB_ID_HDR_EN
        data_nxt    = data_q;
`endif
        unique case (state)
            IDLE: begin
                if (rr.hit) begin
                    last_nxt  = rr.idx;
                    grant_nxt = rr.idx;
`ifdef UART_ARB_ID_HDR_EN
                    data_nxt  = rr.data;
                    byte_nxt  = ID_BASE + {5'd0, rr.idx};
                    state_nxt = HDR_ISSUE;
`else
                    byte_nxt  = rr.data;
                    state_nxt = ISSUE;
`endif
                end
            end
`ifdef UART_ARB_ID_HDR_EN
            HDR_ISSUE: begin
                tx_dv_nxt = 1'b1;
                cnt_nxt   = '0;
                state_nxt = HDR_WAIT;
            end
            HDR_WAIT: begin
                // A header timeout drops the transfer without an ack so the requester retries.
                if (i_tx_done) begin
                    byte_nxt  = data_q;
                    state_nxt = ISSUE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (wd_hit) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
`endif
            ISSUE: begin
                tx_dv_nxt = 1'b1;
                ack_nxt   = N_REQ'(1) << last;
                cnt_nxt   = '0;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Done is checked first so a coincident done suppresses the timeout.
                if (i_tx_done) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (wd_hit) begin
                        timeout_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last       <= 3'(N_REQ - 1);
            cnt        <= '0;
            o_tx_dv    <= 1'b0;
            o_req_ack  <= '0;
            o_tx_byte  <= '0;
            o_grant_id <= '0;
            o_timeout  <= 1'b0;
`ifdef UART_ARB_ID_HDR_EN
            data_q     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            cnt        <= cnt_nxt;
            o_tx_dv    <= tx_dv_nxt;
            o_req_ack  <= ack_nxt;
            o_tx_byte  <= byte_nxt;
            o_grant_id <= grant_nxt;
            o_timeout  <= timeout_nxt;
`ifdef UART_ARB_ID_HDR_EN
            data_q     <= data_nxt;
`endif
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized requesters/transmitter, checked every
// cycle against a transfer-timing reference model.
module tb_uart_tx_arbiter;
    localparam int         N   = 4;
    localparam int         TO  = 2048;
    localparam logic [7:0] IDB = 8'hA0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_dv = '0;
    logic [8*N-1:0] req_byte = '0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   req_ack;
    logic           tx_dv;
    logic [7:0]     tx_byte;
    logic           busy;
    logic [2:0]     grant_id;
    logic           tx_to;

    uart_tx_arbiter #(.N_REQ(N), .ID_BASE(IDB), .DONE_TIMEOUT(TO)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_req_dv(req_dv), .i_req_byte(req_byte),
        .o_req_ack(req_ack), .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_done(tx_done),
        .o_busy(busy), .o_grant_id(grant_id), .o_timeout(tx_to)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a transfer is granted at edge g, its strobe is seen after edge iss+1,
    // done counts from edge iss+2, and the watchdog fires at edge iss+1+TO.
    int         ecyc = 0;
    bit         m_xfer = 0, m_hdr = 0, m_to = 0;
    int         m_last = N - 1, m_w = 0, m_iss = 0;
    logic [7:0] m_byte = 0, m_data = 0;
    logic       e_dv, e_busy, e_to;
    logic [N-1:0] e_ack;

    task automatic model_edge();
        bit was, found;
        ecyc++;
        m_to = 0;
        if (!rst_n) begin
            m_xfer = 0; m_hdr = 0; m_last = N - 1; m_w = 0; m_byte = 0;
        end else begin
            was = m_xfer;
            if (m_xfer && ecyc >= m_iss + 2) begin
                if (tx_done) begin
                    if (m_hdr) begin m_hdr = 0; m_iss = ecyc; m_byte = m_data; end
                    else m_xfer = 0;
                end else if (ecyc == m_iss + 1 + TO) begin
                    m_to = 1; m_xfer = 0; m_hdr = 0;
                end
            end
            if (!was && req_dv != '0) begin
                found = 0;
                for (int i = 1; i <= N; i++) begin
                    if (!found && req_dv[(m_last + i) % N]) begin
                        found = 1; m_w = (m_last + i) % N;
                    end
                end
                m_last = m_w; m_xfer = 1; m_iss = ecyc;
                m_data = req_byte[8*m_w +: 8];
`ifdef UART_ARB_ID_HDR_EN
                m_hdr = 1; m_byte = IDB + 8'(m_w);
`else
                m_byte = m_data;
`endif
            end
        end
        e_busy = m_xfer;
        e_dv   = m_xfer && (ecyc == m_iss + 1);
        e_ack  = (e_dv && !m_hdr) ? N'(1) << m_w : '0;
        e_to   = m_to;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tx_dv", tx_dv, e_dv);
        chk("req_ack", req_ack, e_ack);
        chk("tx_byte", tx_byte, m_byte);
        chk("grant_id", grant_id, m_w);
        chk("busy", busy, e_busy);
        chk("timeout", tx_to, e_to);
    endtask

    task automatic do_reset();
        rst_n = 0; req_dv = '0; tx_done = 0;
        step(); step();
        rst_n = 1;
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin step(); n++; end while (!tx_dv && n < 10);
        chk(tag, tx_dv, 1);
    endtask

    int done_cd = 0;

    task automatic drive_random();
        rst_n = ($urandom_range(0, 1999) != 0);
        for (int k = 0; k < N; k++) begin
            if (e_ack[k]) begin
                req_dv[k] = 1'($urandom_range(0, 1));
                req_byte[8*k +: 8] = 8'($urandom);
            end else if (!req_dv[k]) begin
                if ($urandom_range(0, 5) == 0) begin
                    req_dv[k] = 1; req_byte[8*k +: 8] = 8'($urandom);
                end
            end else if ($urandom_range(0, 39) == 0) begin
                req_dv[k] = 0;
            end
        end
        tx_done = 0;
        if (e_dv) done_cd = ($urandom_range(0, 59) == 0) ? -1 : int'($urandom_range(1, 12));
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) tx_done = 1;
        end else if ($urandom_range(0, 49) == 0) begin
            tx_done = 1;
        end
    endtask

    logic [7:0] seen[$];
    logic [N-1:0] seen_ack[$];
    logic [7:0] t2_exp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int cd, idle;

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
`ifndef UART_ARB_ID_HDR_EN
        // single request, strobe two edges after dv
        req_byte = '0; req_byte[23:16] = 8'hBE; req_dv = 4'b0100;
        step();
        chk("t1_early_dv", tx_dv, 0);
        step();
        chk("t1_dv", tx_dv, 1);
        chk("t1_byte", tx_byte, 8'hBE);
        chk("t1_ack", req_ack, 4'b0100);
        chk("t1_gid", grant_id, 2);
        req_dv = '0;
        repeat (869) step();
        chk("t1_busy_hold", busy, 1);
        tx_done = 1; step(); tx_done = 0;
        chk("t1_busy_fall", busy, 0);
        chk("t1_byte_hold", tx_byte, 8'hBE);

        // all requesters valid: fair rotation, one idle cycle between transfers
        do_reset();
        req_byte = {8'h44, 8'h33, 8'h22, 8'h11}; req_dv = '1;
        seen.delete(); cd = 0; idle = 0;
        for (int c = 0; c < 200 && seen.size() < 5; c++) begin
            step();
            tx_done = 0;
            if (!busy && seen.size() > 0) idle++;
            if (tx_dv) begin seen.push_back(tx_byte); cd = 3; end
            else if (cd > 0) begin cd--; if (cd == 0) tx_done = 1; end
        end
        tx_done = 0;
        chk("t2_count", seen.size(), 5);
        for (int i = 0; i < seen.size() && i < 5; i++) chk("t2_order", seen[i], t2_exp[i]);
        chk("t2_idle", idle, 4);
        req_dv = '0;
        repeat (4) step();
        tx_done = 1; step(); tx_done = 0;

        // watchdog
        do_reset();
        req_byte[7:0] = 8'h5A; req_dv = 4'b0001;
        wait_strobe("t3_strobe");
        chk("t3_byte", tx_byte, 8'h5A);
        req_dv = '0;
        cd = 0;
        while (!tx_to && cd < TO + 10) begin step(); cd++; end
        chk("t3_to_dist", cd, TO);
        chk("t3_busy", busy, 0);
        req_byte[7:0] = 8'h77; req_dv = 4'b0001;
        wait_strobe("t3_next_strobe");
        chk("t3_next_byte", tx_byte, 8'h77);
        req_dv = '0; tx_done = 1; step(); tx_done = 0;
        chk("t3_next_done", busy, 0);

        // reset mid-transfer
        do_reset();
        req_byte[23:16] = 8'h99; req_dv = 4'b0100;
        wait_strobe("t4_strobe");
        req_dv = '0;
        repeat (5) step();
        rst_n = 0; step(); rst_n = 1;
        chk("t4_byte", tx_byte, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ack", req_ack, 0);
        req_byte = {8'hD4, 8'hD3, 8'hD2, 8'hD1}; req_dv = '1;
        wait_strobe("t4_strobe2");
        chk("t4_gid", grant_id, 0);
        chk("t4_byte2", tx_byte, 8'hD1);
        req_dv = '0; tx_done = 1; step(); tx_done = 0;

        // done on the same edge the counter reaches the limit
        do_reset();
        req_byte[31:24] = 8'hC3; req_dv = 4'b1000;
        wait_strobe("t5_strobe");
        req_dv = '0;
        repeat (TO - 1) step();
        chk("t5_busy_pre", busy, 1);
        tx_done = 1; step(); tx_done = 0;
        chk("t5_to", tx_to, 0);
        chk("t5_busy", busy, 0);
`else
        // header byte precedes the data byte; ack only with the data strobe
        req_byte = '0; req_byte[15:8] = 8'hBE; req_dv = 4'b0010;
        seen.delete(); seen_ack.delete(); cd = 0;
        for (int c = 0; c < 40 && seen.size() < 2; c++) begin
            step();
            tx_done = 0;
            if (req_ack[1]) req_dv = '0;
            if (tx_dv) begin seen.push_back(tx_byte); seen_ack.push_back(req_ack); cd = 2; end
            else if (cd > 0) begin cd--; if (cd == 0) tx_done = 1; end
        end
        chk("t6_count", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("t6_hdr", seen[0], 8'hA1);
            chk("t6_hdr_ack", seen_ack[0], 0);
            chk("t6_data", seen[1], 8'hBE);
            chk("t6_data_ack", seen_ack[1], 4'b0010);
        end
        req_dv = '0;
        repeat (3) step();
        tx_done = 1; step(); tx_done = 0;
`endif

        // randomized traffic
        do_reset();
        done_cd = 0;
        for (int c = 0; c < 6000; c++) begin
            drive_random();
            step();
        end
        rst_n = 1; req_dv = '0; tx_done = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between N_REQ byte producers.
- Selects a requester round-robin, latches its byte, and pulses the transmitter's one-cycle data-valid strobe.
- Waits for the transmitter's done pulse before granting the next requester.
- Sits between the application-side byte sources and the UART TX path inside top; a watchdog recovers from a missing done pulse.

Parameters:
N_REQ, 4, number of requesters (2..8); the grant index is 3 bits wide.
ID_BASE, 8'hA0, base value of the header byte (optional feature only).
DONE_TIMEOUT, 2048, maximum clk cycles to wait for i_tx_done after a strobe before aborting (must be ≥ 1).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
i_rst_n  input  1  synchronous, active-low reset.
i_req_dv  input  N_REQ  per-requester valid; held high with its byte until acked.
i_req_byte  input  8*N_REQ  requester k's byte is at bits [8k+7:8k].
o_req_ack  output  N_REQ  one-cycle pulse: requester's byte has been handed to the transmitter.
o_tx_dv  output  1  one-cycle strobe to the UART TX.
o_tx_byte  output  8  byte to the UART TX; stable from the strobe until done.
i_tx_done  input  1  one-cycle pulse from the UART TX after the stop bit.
o_busy  output  1  high whenever the state is not IDLE.
o_grant_id  output  3  index of the current or last granted requester.
o_timeout  output  1  one-cycle pulse when the watchdog aborts.

Behaviour:
- Reset (i_rst_n low at a clk edge):
  - All outputs go to 0; state goes to IDLE.
  - Round-robin pointer last = N_REQ-1, so requester 0 has first priority.
  - Reset mid-transfer abandons the transfer and emits no ack.
- State IDLE:
  - If any i_req_dv bit is high, grant the first requester searching from last+1 upward, with wrap-around.
  - Latch its byte into o_tx_byte, set o_grant_id and last to the winner, then go to ISSUE.
- State ISSUE (one cycle):
  - o_tx_dv=1 and o_req_ack[winner]=1 in the same cycle.
  - Clear the watchdog counter, then go to WAIT_DONE.
- State WAIT_DONE:
  - On i_tx_done, go to IDLE.
  - Otherwise increment the counter. When it reaches DONE_TIMEOUT, pulse o_timeout and go to IDLE.
- Arbitration latency:
  - First strobe occurs 2 cycles after i_req_dv rises while in IDLE.
  - Back-to-back grants have exactly 1 IDLE cycle after done.
- Requester handling:
  - Requesters whose dv drops before grant are skipped; no ack is given.
  - Only the winner's dv is sampled at grant; changes on other lines mid-transfer are ignored.
  - i_tx_done outside WAIT_DONE (or the header wait state) is ignored.
- If i_tx_done and the timeout fall in the same cycle, done wins and there is no o_timeout pulse.
- o_tx_byte holds its value after the transfer until the next grant.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0.
  - No requester waits more than N_REQ transfers.

Optional Feature:
UART_ARB_ID_HDR_EN
- Defined:
  - Each transfer is preceded by a header byte ID_BASE + grant index (8-bit wrap), sent using the same strobe/done/timeout flow in added states HDR_ISSUE and HDR_WAIT, entered from IDLE.
  - After the header's done, go to ISSUE for the data byte. o_req_ack pulses only at the data strobe.
  - A header timeout returns to IDLE with no ack, so the requester retries.
- Undefined: header states are absent; only data bytes are sent.

Test Plan:
1. Reset then single request: i_req_dv=4'b0100, byte2=8'hBE → o_tx_dv at cycle 2 with o_tx_byte=8'hBE, o_req_ack=4'b0100 in the same cycle, o_grant_id=2; model done after 870 cycles → o_busy falls 1 cycle later.
2. All four valid, bytes 8'h11,8'h22,8'h33,8'h44, held until ack → transmitted order 11,22,33,44,11; exactly 1 IDLE cycle between done and next grant.
3. Watchdog: request 8'h5A, never pulse done → o_timeout pulse exactly DONE_TIMEOUT cycles after the WAIT_DONE entry; next grant proceeds normally.
4. Reset mid-transfer: i_rst_n low for 1 cycle during WAIT_DONE → all outputs 0; next request grants requester 0 first.
5. Done and timeout coincide (done on the cycle the counter reaches DONE_TIMEOUT) → no o_timeout; IDLE on the next cycle.
6. With UART_ARB_ID_HDR_EN, requester 1 byte 8'hBE → bytes transmitted 8'hA1 then 8'hBE; ack coincides with the second strobe only.
